// File: rtl/motor_mixer_if.sv
// +--------------------------------------------------------------------------+
// | Module      : motor_mixer_if                                              |
// | Description : Command/gyro inputs and motor outputs of the quad-X mixer.  |
// |               master = command source side, slave = mixer side.          |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

interface motor_mixer_if;
   logic        UPDATE;
   logic [9:0]  THROTTLE;
   logic [9:0]  AILERON;
   logic [9:0]  ELEVATOR;
   logic [9:0]  RUDDER;
   logic [15:0] GYRO_X;
   logic [15:0] GYRO_Y;
   logic [15:0] GYRO_Z;
   logic [9:0]  MOTOR0;
   logic [9:0]  MOTOR1;
   logic [9:0]  MOTOR2;
   logic [9:0]  MOTOR3;
   logic        VALID;
   logic        ARMED;

   modport master (
      output UPDATE, THROTTLE, AILERON, ELEVATOR, RUDDER,
      output GYRO_X, GYRO_Y, GYRO_Z,
      input  MOTOR0, MOTOR1, MOTOR2, MOTOR3, VALID, ARMED
   );

   modport slave (
      input  UPDATE, THROTTLE, AILERON, ELEVATOR, RUDDER,
      input  GYRO_X, GYRO_Y, GYRO_Z,
      output MOTOR0, MOTOR1, MOTOR2, MOTOR3, VALID, ARMED
   );
endinterface

`default_nettype wire

// File: rtl/motor_mixer.sv
// +--------------------------------------------------------------------------+
// | Module      : motor_mixer                                                 |
// | Description : Quad-X motor mixer, 3-stage pipeline (stick offsets and     |
// |               gyro correction, mixing sums, clamp/arm gating) plus a      |
// |               stick-gesture arm/disarm state machine.                     |
// |               Build macro MOTOR_MIXER_GYRO_EN enables gyro correction;    |
// |               without it the gyro inputs are ignored (pure stick mixing). |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module motor_mixer #(
   parameter int KP_SHIFT   = 6,
   parameter int THR_MIN    = 40,
   parameter int RUD_ARM_HI = 960,
   parameter int RUD_ARM_LO = 64,
   parameter int ARM_HOLD   = 100,
   parameter int MOTOR_IDLE = 60
) (
   input  logic          CLK,
   input  logic          RST,
   motor_mixer_if.slave  mix_io
);

   localparam int         c_CNT_W      = $clog2(ARM_HOLD + 1);
   localparam logic [9:0] c_THR_MIN    = 10'(THR_MIN);
   localparam logic [9:0] c_RUD_ARM_HI = 10'(RUD_ARM_HI);
   localparam logic [9:0] c_RUD_ARM_LO = 10'(RUD_ARM_LO);
   localparam logic [9:0] c_MOTOR_IDLE = 10'(MOTOR_IDLE);
   localparam logic [c_CNT_W-1:0] c_ARM_LAST = c_CNT_W'(ARM_HOLD - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   localparam logic [0:0] c_ST_DISARMED = 1'b0;
   localparam logic [0:0] c_ST_ARMED    = 1'b1;

   // ---------------------------------------------------------------------
   // Stage 1 signals: centred sticks and scaled gyro rates
   // ---------------------------------------------------------------------
   logic signed [10:0] a_d, e_d, r_d;
   logic signed [10:0] a_q, e_q, r_q;
   logic signed [13:0] gx_d, gy_d, gz_d;
   logic signed [13:0] gx_q, gy_q, gz_q;
   logic [9:0]         t1_q;
   logic               v1_q;

   // ---------------------------------------------------------------------
   // Stage 2 signals: per-motor mixing sums
   // ---------------------------------------------------------------------
   logic signed [13:0] roll_d, pitch_d, yaw_d, thr_d;
   logic [3:0][13:0]   m_d;
   logic [3:0][13:0]   m_q;
   logic [9:0]         t2_q;
   logic               v2_q;

   // ---------------------------------------------------------------------
   // Stage 3 signals: gated, clamped motor commands
   // ---------------------------------------------------------------------
   logic [3:0][9:0]    motor_d;
   logic [3:0][9:0]    motor_q;
   logic               valid_q;

   // ---------------------------------------------------------------------
   // Arm FSM signals
   // ---------------------------------------------------------------------
   logic [0:0]         state_d, state_q;
   logic [c_CNT_W-1:0] cnt_d, cnt_q;
   logic               w_thr_low;
   logic               w_arm_gesture;
   logic               w_disarm_gesture;

   // Centre the stick commands around zero (11-bit signed, -512..511).
   always_comb begin
      a_d = $signed({1'b0, mix_io.AILERON}  - 11'd512);
      e_d = $signed({1'b0, mix_io.ELEVATOR} - 11'd512);
      r_d = $signed({1'b0, mix_io.RUDDER}   - 11'd512);
   end

`ifdef MOTOR_MIXER_GYRO_EN
   // Scale the gyro rates; the arithmetic shift keeps the sign, and after a
   // shift of 2 or more the result always fits in 14 bits.
   always_comb begin
      gx_d = 14'($signed(mix_io.GYRO_X) >>> KP_SHIFT);
      gy_d = 14'($signed(mix_io.GYRO_Y) >>> KP_SHIFT);
      gz_d = 14'($signed(mix_io.GYRO_Z) >>> KP_SHIFT);
   end
`else
   // Gyro correction disabled: rate terms are zero, stick mixing only.
   always_comb begin
      gx_d = '0;
      gy_d = '0;
      gz_d = '0;
   end

   // Gyro inputs and shift are intentionally left unconnected in this build.
   logic w_gyro_unused;
   assign w_gyro_unused = ^{mix_io.GYRO_X, mix_io.GYRO_Y, mix_io.GYRO_Z};
   localparam int c_KP_SHIFT_unused = KP_SHIFT;
`endif

   // Stage 1 register: capture offsets, scaled rates and throttle on UPDATE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         v1_q <= 1'b0;
         a_q  <= '0;
         e_q  <= '0;
         r_q  <= '0;
         gx_q <= '0;
         gy_q <= '0;
         gz_q <= '0;
         t1_q <= '0;
      end else begin
         v1_q <= mix_io.UPDATE;
         if (mix_io.UPDATE) begin
            a_q  <= a_d;
            e_q  <= e_d;
            r_q  <= r_d;
            gx_q <= gx_d;
            gy_q <= gy_d;
            gz_q <= gz_d;
            t1_q <= mix_io.THROTTLE;
         end
      end
   end

   // Axis terms and quad-X mixing; 14 bits hold the worst case
   // (1023 + 3 * 1024) so no intermediate can wrap.
   always_comb begin
      roll_d  = $signed({{3{a_q[10]}}, a_q}) - gx_q;
      pitch_d = $signed({{3{e_q[10]}}, e_q}) - gy_q;
      yaw_d   = $signed({{3{r_q[10]}}, r_q}) - gz_q;
      thr_d   = $signed({4'd0, t1_q});
      m_d[0]  = thr_d + roll_d - pitch_d - yaw_d;   // front-left
      m_d[1]  = thr_d - roll_d - pitch_d + yaw_d;   // front-right
      m_d[2]  = thr_d - roll_d + pitch_d - yaw_d;   // rear-right
      m_d[3]  = thr_d + roll_d + pitch_d + yaw_d;   // rear-left
   end

   // Stage 2 register: mixing sums and throttle for the idle check.
   always_ff @(posedge CLK) begin
      if (RST) begin
         v2_q <= 1'b0;
         m_q  <= '0;
         t2_q <= '0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) begin
            m_q  <= m_d;
            t2_q <= t1_q;
         end
      end
   end

   // Saturate a signed 14-bit sum into the unsigned 0..1023 motor range.
   function automatic logic [9:0] clamp10(input logic [13:0] s);
      if (s[13]) begin
         return 10'd0;
      end else if (|s[12:10]) begin
         return 10'd1023;
      end else begin
         return s[9:0];
      end
   endfunction

   // Output selection: off when disarmed, idle on low throttle, else mix.
   // The arm state is the one current at this stage, so a disarm takes
   // effect on the very next result.
   always_comb begin
      motor_d = '0;
      for (int i = 0; i < 4; i++) begin
         if (state_q != c_ST_ARMED) begin
            motor_d[i] = 10'd0;
         end else if (t2_q <= c_THR_MIN) begin
            motor_d[i] = c_MOTOR_IDLE;
         end else begin
            motor_d[i] = clamp10(m_q[i]);
         end
      end
   end

   // Stage 3 register: outputs hold between results, VALID pulses once.
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= 1'b0;
         motor_q <= '0;
      end else begin
         valid_q <= v2_q;
         if (v2_q) begin
            motor_q <= motor_d;
         end
      end
   end

   // Gesture decode from the raw sticks.
   always_comb begin
      w_thr_low        = (mix_io.THROTTLE <= c_THR_MIN);
      w_arm_gesture    = w_thr_low && (mix_io.RUDDER >= c_RUD_ARM_HI);
      w_disarm_gesture = w_thr_low && (mix_io.RUDDER <= c_RUD_ARM_LO);
   end

   // Arm FSM next state: count consecutive qualifying strobes; any
   // non-qualifying strobe restarts the count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (mix_io.UPDATE) begin
         case (state_q)
            c_ST_DISARMED: begin
               if (!w_arm_gesture) begin
                  cnt_d = '0;
               end else if (cnt_q == c_ARM_LAST) begin
                  cnt_d   = '0;
                  state_d = c_ST_ARMED;
               end else begin
                  cnt_d = cnt_q + c_CNT_ONE;
               end
            end
            c_ST_ARMED: begin
               if (!w_disarm_gesture) begin
                  cnt_d = '0;
               end else if (cnt_q == c_ARM_LAST) begin
                  cnt_d   = '0;
                  state_d = c_ST_DISARMED;
               end else begin
                  cnt_d = cnt_q + c_CNT_ONE;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = c_ST_DISARMED;
            end
         endcase
      end
   end

   // Arm FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= c_ST_DISARMED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mix_io.MOTOR0 = motor_q[0];
   assign mix_io.MOTOR1 = motor_q[1];
   assign mix_io.MOTOR2 = motor_q[2];
   assign mix_io.MOTOR3 = motor_q[3];
   assign mix_io.VALID  = valid_q;
   assign mix_io.ARMED  = (state_q == c_ST_ARMED);

endmodule

`default_nettype wire
